// File: rtl/sap_alu_regfile.sv
// General register file with a multi-cycle ALU (add/sub/logic/shift, optional multiply).
// Define ALU_MUL_EN to build the shift-add multiplier for opcode 11.
module sap_alu_regfile #(
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 4,
  localparam int SELW     = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] bus_in_i,
  input  logic             load_i,
  input  logic [SELW-1:0]  load_sel_i,
  input  logic             out_en_i,
  input  logic [SELW-1:0]  out_sel_i,
  output logic [WIDTH-1:0] bus_out_o,
  output logic             bus_oe_o,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [SELW-1:0]  ra_sel_i,
  input  logic [SELW-1:0]  rb_sel_i,
  input  logic [SELW-1:0]  rd_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             flag_z_o,
  output logic             flag_c_o,
  output logic             flag_n_o,
  output logic             flag_v_o
);

  localparam int MSB = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [3:0]       op_q;
  logic [SELW-1:0]  ra_q, rb_q, rd_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;
  logic             busy_q, done_q;
  logic             flag_z_q, flag_c_q, flag_n_q, flag_v_q;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mul_hi_q, mul_hi_d;
  logic [WIDTH:0]   mul_sum_d;
`endif

  logic [WIDTH-1:0] a_d, b_d, res_d, acc_d;
  logic [WIDTH:0]   sum_d, dif_d, inc_d, dec_d;
  logic [SHW-1:0]   amt_d;
  logic             c_d, v_d, wb_d, upd_d, go_shift_d, sc_d;

  assign bus_oe_o  = out_en_i;
  assign bus_out_o = out_en_i ? regs_q[out_sel_i] : '0;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign flag_z_o  = flag_z_q;
  assign flag_c_o  = flag_c_q;
  assign flag_n_o  = flag_n_q;
  assign flag_v_o  = flag_v_q;

  // Single-cycle datapath, evaluated in EXEC from the live register file
  always_comb begin
    a_d   = regs_q[ra_q];
    b_d   = regs_q[rb_q];
    sum_d = {1'b0, a_d} + {1'b0, b_d};
    dif_d = {1'b0, a_d} - {1'b0, b_d};
    inc_d = {1'b0, a_d} + {{WIDTH{1'b0}}, 1'b1};
    dec_d = {1'b0, a_d} - {{WIDTH{1'b0}}, 1'b1};
    amt_d = (b_d[SHW-1:0] >= SHW'(WIDTH)) ? SHW'(WIDTH) : b_d[SHW-1:0];
    res_d = '0;
    c_d = 1'b0;
    v_d = 1'b0;
    wb_d = 1'b0;
    upd_d = 1'b0;
    go_shift_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = sum_d[MSB:0];
        c_d   = sum_d[WIDTH];
        v_d   = (a_d[MSB] == b_d[MSB]) && (res_d[MSB] != a_d[MSB]);
        wb_d  = 1'b1;
        upd_d = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        res_d = dif_d[MSB:0];
        c_d   = ~dif_d[WIDTH];
        v_d   = (a_d[MSB] != b_d[MSB]) && (res_d[MSB] != a_d[MSB]);
        wb_d  = (op_q == OP_SUB);
        upd_d = 1'b1;
      end
      OP_AND: begin res_d = a_d & b_d; wb_d = 1'b1; upd_d = 1'b1; end
      OP_OR:  begin res_d = a_d | b_d; wb_d = 1'b1; upd_d = 1'b1; end
      OP_XOR: begin res_d = a_d ^ b_d; wb_d = 1'b1; upd_d = 1'b1; end
      OP_NOT: begin res_d = ~a_d;      wb_d = 1'b1; upd_d = 1'b1; end
      OP_INC: begin
        res_d = inc_d[MSB:0];
        c_d   = inc_d[WIDTH];
        v_d   = ~a_d[MSB] && res_d[MSB];
        wb_d  = 1'b1;
        upd_d = 1'b1;
      end
      OP_DEC: begin
        res_d = dec_d[MSB:0];
        c_d   = ~dec_d[WIDTH];
        v_d   = a_d[MSB] && ~res_d[MSB];
        wb_d  = 1'b1;
        upd_d = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        if (amt_d == '0) begin
          res_d = a_d;
          wb_d  = 1'b1;
          upd_d = 1'b1;
        end else begin
          go_shift_d = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      OP_MUL: go_shift_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // One iteration of the serial unit; sc_d is the carry flag if this is the last step
  always_comb begin
    acc_d = acc_q;
    sc_d  = 1'b0;
`ifdef ALU_MUL_EN
    mul_sum_d = '0;
    mul_hi_d  = mul_hi_q;
`endif
    case (op_q)
      OP_SHL: begin
        sc_d  = acc_q[MSB];
        acc_d = {acc_q[MSB-1:0], 1'b0};
      end
      OP_SHR: begin
        sc_d  = acc_q[0];
        acc_d = {1'b0, acc_q[MSB:1]};
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        mul_sum_d = {1'b0, mul_hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_hi_d  = mul_sum_d[WIDTH:1];
        acc_d     = {mul_sum_d[0], acc_q[MSB:1]};
        sc_d      = |mul_hi_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mul_hi_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_i) regs_q[load_sel_i] <= bus_in_i;
          if (start_i) begin
            op_q    <= op_i;
            ra_q    <= ra_sel_i;
            rb_q    <= rb_sel_i;
            rd_q    <= rd_sel_i;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (wb_d) regs_q[rd_q] <= res_d;
          if (upd_d) begin
            flag_z_q <= (res_d == '0);
            flag_n_q <= res_d[MSB];
            flag_c_q <= c_d;
            flag_v_q <= v_d;
          end
          if (go_shift_d) begin
            acc_q   <= a_d;
            cnt_q   <= amt_d;
            state_q <= SHIFT;
`ifdef ALU_MUL_EN
            if (op_q == OP_MUL) begin
              acc_q    <= b_d;
              mcand_q  <= a_d;
              mul_hi_q <= '0;
              cnt_q    <= SHW'(WIDTH);
            end
`endif
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
`ifdef ALU_MUL_EN
          mul_hi_q <= mul_hi_d;
`endif
          if (cnt_q == SHW'(1)) begin
            regs_q[rd_q] <= acc_d;
            flag_z_q     <= (acc_d == '0);
            flag_n_q     <= acc_d[MSB];
            flag_c_q     <= sc_d;
            flag_v_q     <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_alu_regfile.sv
// Randomised self-checking bench for sap_alu_regfile against an arithmetic reference model.
// Honours ALU_MUL_EN the same way as the design when compiled together.
module tb_sap_alu_regfile;

  localparam int W  = 8;
  localparam int NR = 4;
  localparam int SW = 2;
  localparam int M  = 255;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [W-1:0]  bus_in_i;
  logic          load_i;
  logic [SW-1:0] load_sel_i;
  logic          out_en_i;
  logic [SW-1:0] out_sel_i;
  logic [W-1:0]  bus_out_o;
  logic          bus_oe_o;
  logic          start_i;
  logic [3:0]    op_i;
  logic [SW-1:0] ra_sel_i, rb_sel_i, rd_sel_i;
  logic          busy_o, done_o;
  logic          flag_z_o, flag_c_o, flag_n_o, flag_v_o;

  always #5 clk_i = ~clk_i;

  sap_alu_regfile #(.WIDTH(W), .NUM_REGS(NR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus_in_i(bus_in_i), .load_i(load_i),
    .load_sel_i(load_sel_i), .out_en_i(out_en_i), .out_sel_i(out_sel_i),
    .bus_out_o(bus_out_o), .bus_oe_o(bus_oe_o), .start_i(start_i), .op_i(op_i),
    .ra_sel_i(ra_sel_i), .rb_sel_i(rb_sel_i), .rd_sel_i(rd_sel_i),
    .busy_o(busy_o), .done_o(done_o), .flag_z_o(flag_z_o), .flag_c_o(flag_c_o),
    .flag_n_o(flag_n_o), .flag_v_o(flag_v_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mreg [NR];
  bit mz, mc, mn, mv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 6))
      0: return 0;
      1: return 1;
      2: return 'h7F;
      3: return 'h80;
      4: return 'hFF;
      default: return int'($urandom_range(0, M));
    endcase
  endfunction

  // Reference behaviour of one operation on operand values a, b
  task automatic model_op(input int op, input int a, input int b, output int r,
                          output bit wb, output bit upd, output bit c, output bit v,
                          output int lat);
    int k, p;
    r = 0; wb = 0; upd = 0; c = 0; v = 0; lat = 2;
    case (op)
      0: begin r = (a + b) & M; c = (a + b) > M; v = (sx(a) + sx(b) > 127) || (sx(a) + sx(b) < -128); wb = 1; upd = 1; end
      1, 8: begin r = (a - b) & M; c = (a >= b); v = (sx(a) - sx(b) > 127) || (sx(a) - sx(b) < -128); wb = (op == 1); upd = 1; end
      2: begin r = a & b; wb = 1; upd = 1; end
      3: begin r = a | b; wb = 1; upd = 1; end
      4: begin r = a ^ b; wb = 1; upd = 1; end
      5: begin r = (~a) & M; wb = 1; upd = 1; end
      6: begin r = (a + 1) & M; c = (a == M); v = (sx(a) + 1 > 127); wb = 1; upd = 1; end
      7: begin r = (a - 1) & M; c = (a >= 1); v = (sx(a) - 1 < -128); wb = 1; upd = 1; end
      9, 10: begin
        k = b & 15;
        if (k > W) k = W;
        if (op == 9) begin
          r = (a << k) & M;
          c = (k == 0) ? 1'b0 : 1'((a >> (W - k)) & 1);
        end else begin
          r = a >> k;
          c = (k == 0) ? 1'b0 : 1'((a >> (k - 1)) & 1);
        end
        wb = 1; upd = 1; lat = 2 + k;
      end
`ifdef ALU_MUL_EN
      11: begin p = a * b; r = p & M; c = (p >> W) != 0; wb = 1; upd = 1; lat = W + 2; end
`endif
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NR; i++) begin
      out_en_i = 1'b1;
      out_sel_i = SW'(i);
      #1;
      check($sformatf("%s reg%0d", tag, i), 32'(bus_out_o), 32'(mreg[i]));
    end
    check({tag, " bus_oe"}, 32'(bus_oe_o), 32'd1);
    out_en_i = 1'b0;
    #1;
    check({tag, " bus_off"}, {31'd0, bus_oe_o} | 32'(bus_out_o), 32'd0);
    check({tag, " flags"}, {28'd0, flag_z_o, flag_c_o, flag_n_o, flag_v_o}, {28'd0, mz, mc, mn, mv});
  endtask

  task automatic do_load(input int sel, input int val);
    load_i = 1'b1; load_sel_i = SW'(sel); bus_in_i = W'(val);
    tick();
    load_i = 1'b0;
    mreg[sel] = val;
  endtask

  task automatic run_op(input int op, input int ra, input int rb, input int rd,
                        input bit with_load, input int lsel, input int lval, input bit junk);
    int r, lat, n, gaps;
    bit wb, upd, c, v;
    start_i = 1'b1; op_i = 4'(op);
    ra_sel_i = SW'(ra); rb_sel_i = SW'(rb); rd_sel_i = SW'(rd);
    if (with_load) begin
      load_i = 1'b1; load_sel_i = SW'(lsel); bus_in_i = W'(lval);
      mreg[lsel] = lval;
    end
    model_op(op, mreg[ra], mreg[rb], r, wb, upd, c, v, lat);
    tick();
    start_i = 1'b0; load_i = 1'b0;
    n = 1; gaps = 0;
    while (done_o !== 1'b1 && n < 40) begin
      if (busy_o !== 1'b1) gaps++;
      if (junk) begin
        start_i = 1'b1; op_i = 4'($urandom_range(0, 15));
        ra_sel_i = SW'($urandom_range(0, NR - 1)); rd_sel_i = SW'($urandom_range(0, NR - 1));
        load_i = 1'b1; load_sel_i = SW'($urandom_range(0, NR - 1)); bus_in_i = W'($urandom_range(0, M));
      end
      tick();
      n++;
    end
    start_i = 1'b0; load_i = 1'b0;
    check($sformatf("op%0d latency", op), 32'(n), 32'(lat));
    check($sformatf("op%0d busy", op), {31'd0, busy_o} | 32'(gaps << 1), 32'd1);
    tick();
    check($sformatf("op%0d done_pulse", op), {30'd0, done_o, busy_o}, 32'd0);
    if (wb) mreg[rd] = r;
    if (upd) begin mz = (r == 0); mn = r[7]; mc = c; mv = v; end
    check_state($sformatf("op%0d", op));
  endtask

  initial begin
    rst_ni = 1'b0; bus_in_i = '0; load_i = 1'b0; load_sel_i = '0; out_en_i = 1'b0;
    out_sel_i = '0; start_i = 1'b0; op_i = '0; ra_sel_i = '0; rb_sel_i = '0; rd_sel_i = '0;
    for (int i = 0; i < NR; i++) mreg[i] = 0;
    mz = 0; mc = 0; mn = 0; mv = 0;
    #12;
    check("reset busy_done", {30'd0, busy_o, done_o}, 32'd0);
    check_state("reset");
    rst_ni = 1'b1;
    tick();

    // Directed cases
    do_load(0, 'h01); do_load(1, 'h01);
    run_op(0, 0, 1, 2, 0, 0, 0, 0);
    run_op(1, 0, 1, 3, 0, 0, 0, 0);
    do_load(0, 'h00);
    run_op(1, 0, 1, 3, 0, 0, 0, 0);
    do_load(0, 'h7F);
    run_op(0, 0, 1, 2, 0, 0, 0, 0);
    do_load(0, 'h81); do_load(1, 'h03);
    run_op(9, 0, 1, 0, 0, 0, 0, 1);
    do_load(1, 'h00);
    run_op(9, 0, 1, 0, 0, 0, 0, 0);
    run_op(10, 0, 1, 2, 1, 1, 'h0C, 0);
    do_load(0, 'h05); do_load(1, 'h09);
    run_op(8, 0, 1, 2, 0, 0, 0, 0);
    run_op(13, 0, 1, 2, 0, 0, 0, 1);
    do_load(0, 'h10); do_load(1, 'h11);
    run_op(11, 0, 1, 0, 0, 0, 0, 1);
    run_op(0, 3, 3, 3, 0, 0, 0, 0);

    // Reset in the middle of a shift aborts without writeback
    do_load(0, 'h81); do_load(1, 'h05);
    start_i = 1'b1; op_i = 4'd9; ra_sel_i = 0; rb_sel_i = 1; rd_sel_i = 0;
    tick();
    start_i = 1'b0;
    tick(); tick();
    check("pre-abort busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mreg[i] = 0;
    mz = 0; mc = 0; mn = 0; mv = 0;
    check("abort busy_done", {30'd0, busy_o, done_o}, 32'd0);
    check_state("abort");
    #2 rst_ni = 1'b1;
    tick();
    check("post-abort idle", {30'd0, busy_o, done_o}, 32'd0);

    // Randomised operations with random interference while busy
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, NR - 1), rnd_val());
      run_op($urandom_range(0, 15), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
             $urandom_range(0, NR - 1), $urandom_range(0, 2) == 0, $urandom_range(0, NR - 1),
             rnd_val(), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
